// File: rtl/cypher_seq_detector_pkg.sv
// Types shared by the cypher sequence detector and its lock timer.
package cypher_seq_detector_pkg;
`include "cypher_defs.vh"

    typedef enum logic [1:0] {
        COLLECT = `ST_COLLECT,
        CHECK   = `ST_CHECK,
        LOCKED  = `ST_LOCKED
    } state_t;

endpackage

// File: rtl/cypher_defs.vh
// Shared state encodings and the ceil-log2 helper for the cypher detector slice.
`ifndef CYPHER_DEFS_VH
`define CYPHER_DEFS_VH

`define ST_COLLECT 2'b00
`define ST_CHECK   2'b01
`define ST_LOCKED  2'b10

`define CLOG2(x) $clog2(x)

`endif

// File: rtl/cypher_lock_timer.sv
// Lockout countdown: start loads LOCK_CYCLES-1, done flags the final busy cycle.
module cypher_lock_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic busy,
    output logic done
);
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [TW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= TW'(LOCK_CYCLES - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - TW'(1);
        end
    end

    assign done = busy && (cnt == '0);

endmodule

// File: rtl/cypher_seq_detector.sv
// Cypher sequence detector: edge-strobed symbol window compared against a programmable
// cypher, with fail counting and lockout. CYPHER_SLIDING_WINDOW_EN selects sliding mode.
`include "cypher_defs.vh"

module cypher_seq_detector
    import cypher_seq_detector_pkg::*;
#(
    parameter int SYM_W       = 4,
    parameter int CYPHER_LEN  = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [SYM_W*CYPHER_LEN-1:0]         cypher,
    input  logic [SYM_W-1:0]                    in_sym,
    input  logic                                read,
    output logic                                match,
    output logic                                fail,
    output logic                                locked,
    output logic [1:0]                          state,
    output logic [`CLOG2(CYPHER_LEN):0]         sym_count,
    output logic [SYM_W+`CLOG2(CYPHER_LEN)-1:0] sum,
    output logic [SYM_W-1:0]                    last_sym,
    output logic [`CLOG2(MAX_FAIL):0]           fail_cnt
);
    localparam int WIN_W  = SYM_W * CYPHER_LEN;
    localparam int CNT_W  = `CLOG2(CYPHER_LEN) + 1;
    localparam int SUM_W  = SYM_W + `CLOG2(CYPHER_LEN);
    localparam int FCNT_W = `CLOG2(MAX_FAIL) + 1;

    state_t              cur, nxt;
    logic [WIN_W-1:0]    window;
    logic                read_q;
    logic                accept, frame_end;
    logic                chk_pass, chk_fail;
    logic                timer_start, timer_busy, timer_done;
    logic [FCNT_W-1:0]   fail_cnt_inc;

    assign accept       = read && !read_q && (cur == COLLECT);
    assign fail_cnt_inc = (fail_cnt == FCNT_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FCNT_W'(1);
`ifdef CYPHER_SLIDING_WINDOW_EN
    assign frame_end = accept && (sym_count >= CNT_W'(CYPHER_LEN - 1));
`else
    assign frame_end = accept && (sym_count == CNT_W'(CYPHER_LEN - 1));
`endif

    cypher_lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (timer_start),
        .busy    (timer_busy),
        .done    (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= COLLECT;
        else          cur <= nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        nxt         = cur;
        chk_pass    = 1'b0;
        chk_fail    = 1'b0;
        timer_start = 1'b0;
        case (cur)
            COLLECT: if (frame_end) nxt = CHECK;
            CHECK: begin
                nxt = COLLECT;
                if (window == cypher) begin
                    chk_pass = 1'b1;
`ifndef CYPHER_SLIDING_WINDOW_EN
                end else begin
                    chk_fail = 1'b1;
                    if (fail_cnt_inc == FCNT_W'(MAX_FAIL)) begin
                        nxt         = LOCKED;
                        timer_start = 1'b1;
                    end
`endif
                end
            end
            LOCKED:  if (timer_done || !timer_busy) nxt = COLLECT;
            default: nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window    <= '0;
            read_q    <= 1'b0;
            sym_count <= '0;
            sum       <= '0;
            last_sym  <= '0;
            fail_cnt  <= '0;
            match     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            read_q <= read;
            match  <= chk_pass;
            fail   <= chk_fail;
            if (accept) begin
                window   <= {window[WIN_W-SYM_W-1:0], in_sym};
                last_sym <= in_sym;
`ifdef CYPHER_SLIDING_WINDOW_EN
                // Once the window is full, the oldest symbol leaves the running sum.
                if (sym_count == CNT_W'(CYPHER_LEN)) begin
                    sum <= sum + SUM_W'(in_sym) - SUM_W'(window[WIN_W-1 -: SYM_W]);
                end else begin
                    sym_count <= sym_count + CNT_W'(1);
                    sum       <= (sym_count == '0) ? SUM_W'(in_sym) : sum + SUM_W'(in_sym);
                end
`else
                sym_count <= sym_count + CNT_W'(1);
                sum       <= (sym_count == '0) ? SUM_W'(in_sym) : sum + SUM_W'(in_sym);
`endif
            end
`ifndef CYPHER_SLIDING_WINDOW_EN
            if (cur == CHECK) sym_count <= '0;
`endif
            if (chk_pass)      fail_cnt <= '0;
            else if (chk_fail) fail_cnt <= fail_cnt_inc;
            if (cur == LOCKED && nxt == COLLECT) begin
                fail_cnt <= '0;
                window   <= '0;
            end
        end
    end

    assign state  = cur;
    assign locked = (cur == LOCKED);

endmodule

// File: tb/tb_cypher_seq_detector.sv
// Directed bench for cypher_seq_detector (default parameters, cypher 16'h2601).
`timescale 1ns/1ps
module tb_cypher_seq_detector;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cypher = 16'h2601;
    logic [3:0]  in_sym = 4'h0;
    logic        read = 1'b0;
    logic        match, fail, locked;
    logic [1:0]  state;
    logic [2:0]  sym_count;
    logic [5:0]  sum;
    logic [3:0]  last_sym;
    logic [2:0]  fail_cnt;

    int total = 0;
    int bad = 0;
    int n_match = 0;
    int n_fail = 0;

    cypher_seq_detector dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cypher    (cypher),
        .in_sym    (in_sym),
        .read      (read),
        .match     (match),
        .fail      (fail),
        .locked    (locked),
        .state     (state),
        .sym_count (sym_count),
        .sum       (sum),
        .last_sym  (last_sym),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (match) n_match++;
        if (fail)  n_fail++;
    end

    task automatic send_sym(input logic [3:0] s);
        @(negedge clk);
        in_sym = s;
        read   = 1'b1;
        repeat (6) @(negedge clk);
        read = 1'b0;
        @(negedge clk);
    endtask

    // Last symbol of a frame: checks the CHECK cycle and the result pulse, then drops read.
    task automatic send_last(input logic [3:0] s, input logic exp_match);
        @(negedge clk);
        in_sym = s;
        read   = 1'b1;
        @(negedge clk);
        total++;
        if (state !== 2'b01) begin bad++; $display("FAIL check_state got=%b exp=01", state); end
        total++;
        if (match !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL early_pulse got m=%b f=%b exp m=0 f=0", match, fail); end
        @(negedge clk);
        total++;
        if (match !== exp_match || fail !== !exp_match) begin
            bad++; $display("FAIL result_pulse got m=%b f=%b exp m=%b f=%b", match, fail, exp_match, !exp_match);
        end
        read = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({state, match, fail, locked, sym_count, sum, last_sym, fail_cnt} !== 24'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {state, match, fail, locked, sym_count, sum, last_sym, fail_cnt});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (state !== 2'b00 || sym_count !== 3'd0) begin bad++; $display("FAIL after_reset got st=%b cnt=%0d exp 00/0", state, sym_count); end
    endtask

    task automatic test_match();
        int m0;
        m0 = n_match;
        send_sym(4'h2); send_sym(4'h6); send_sym(4'h0);
        total++;
        if (sym_count !== 3'd3 || sum !== 6'd8) begin bad++; $display("FAIL partial_frame got cnt=%0d sum=%0d exp 3/8", sym_count, sum); end
        send_last(4'h1, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (n_match - m0 !== 1) begin bad++; $display("FAIL match_count got=%0d exp=1", n_match - m0); end
        total++;
        if (sum !== 6'd9 || last_sym !== 4'h1 || sym_count !== 3'd0 || fail_cnt !== 3'd0) begin
            bad++; $display("FAIL match_state got sum=%0d last=%0d cnt=%0d fc=%0d exp 9/1/0/0", sum, last_sym, sym_count, fail_cnt);
        end
    endtask

    task automatic test_fail();
        send_sym(4'h0); send_sym(4'h1); send_sym(4'h3);
        send_last(4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (fail_cnt !== 3'd1 || state !== 2'b00 || sum !== 6'd4) begin
            bad++; $display("FAIL fail_frame got fc=%0d st=%b sum=%0d exp 1/00/4", fail_cnt, state, sum);
        end
        send_sym(4'h2); send_sym(4'h6); send_sym(4'h0);
        send_last(4'h1, 1'b1);
        @(negedge clk);
        total++;
        if (fail_cnt !== 3'd0) begin bad++; $display("FAIL fail_cnt_clear got=%0d exp=0", fail_cnt); end
    endtask

    task automatic test_lockout();
        int n_lock;
        logic cnt_moved;
        for (int f = 1; f <= 2; f++) begin
            repeat (4) send_sym(4'h0);
            total++;
            if (fail_cnt !== 3'(f)) begin bad++; $display("FAIL fail_cnt_step got=%0d exp=%0d", fail_cnt, f); end
        end
        repeat (3) send_sym(4'h0);
        send_last(4'h0, 1'b0);
        total++;
        if (locked !== 1'b1 || state !== 2'b10 || fail_cnt !== 3'd3) begin
            bad++; $display("FAIL lock_entry got lk=%b st=%b fc=%0d exp 1/10/3", locked, state, fail_cnt);
        end
        n_lock = 0;
        cnt_moved = 1'b0;
        in_sym = 4'h5;
        while (state == 2'b10 && n_lock < 40) begin
            n_lock++;
            if (sym_count !== 3'd0) cnt_moved = 1'b1;
            read = ~read;
            @(negedge clk);
        end
        read = 1'b0;
        total++;
        if (n_lock !== 16) begin bad++; $display("FAIL lock_length got=%0d exp=16", n_lock); end
        total++;
        if (cnt_moved !== 1'b0) begin bad++; $display("FAIL lock_ignores_read got moved=%b exp=0", cnt_moved); end
        total++;
        if (locked !== 1'b0 || fail_cnt !== 3'd0 || sym_count !== 3'd0) begin
            bad++; $display("FAIL lock_exit got lk=%b fc=%0d cnt=%0d exp 0/0/0", locked, fail_cnt, sym_count);
        end
    endtask

    task automatic test_hold_and_check_toggle();
        @(negedge clk);
        in_sym = 4'h2;
        read   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_sym = 4'(i + 3);
        end
        total++;
        if (sym_count !== 3'd1 || last_sym !== 4'h2 || sum !== 6'd2) begin
            bad++; $display("FAIL held_read got cnt=%0d last=%0d sum=%0d exp 1/2/2", sym_count, last_sym, sum);
        end
        read = 1'b0;
        @(negedge clk);
        send_sym(4'h6); send_sym(4'h0);
        @(negedge clk);
        in_sym = 4'h1;
        read   = 1'b1;
        @(negedge clk);
        total++;
        if (state !== 2'b01) begin bad++; $display("FAIL toggle_check_state got=%b exp=01", state); end
        read = 1'b0;
        #2 read = 1'b1;
        @(negedge clk);
        total++;
        if (match !== 1'b1 || sym_count !== 3'd0) begin bad++; $display("FAIL toggle_match got m=%b cnt=%0d exp 1/0", match, sym_count); end
        @(negedge clk);
        total++;
        if (sym_count !== 3'd0) begin bad++; $display("FAIL check_toggle_dropped got cnt=%0d exp=0", sym_count); end
        read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        send_sym(4'h2); send_sym(4'h6);
        total++;
        if (sym_count !== 3'd2) begin bad++; $display("FAIL pre_reset_count got=%0d exp=2", sym_count); end
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({state, match, fail, locked, sym_count, sum, last_sym, fail_cnt} !== 24'd0) begin
            bad++; $display("FAIL async_reset got=%h exp=0", {state, match, fail, locked, sym_count, sum, last_sym, fail_cnt});
        end
        @(negedge clk);
        reset_n = 1'b1;
        send_sym(4'h2); send_sym(4'h6); send_sym(4'h0);
        send_last(4'h1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_sliding();
        int m0, f0;
        m0 = n_match;
        f0 = n_fail;
        send_sym(4'h7); send_sym(4'h2); send_sym(4'h6); send_sym(4'h0);
        total++;
        if (n_match - m0 !== 0) begin bad++; $display("FAIL slide_no_early_match got=%0d exp=0", n_match - m0); end
        send_sym(4'h1);
        total++;
        if (n_match - m0 !== 1) begin bad++; $display("FAIL slide_match_5th got=%0d exp=1", n_match - m0); end
        send_sym(4'h5);
        total++;
        if (n_match - m0 !== 1 || n_fail - f0 !== 0) begin
            bad++; $display("FAIL slide_pulses got m=%0d f=%0d exp 1/0", n_match - m0, n_fail - f0);
        end
        total++;
        if (sum !== 6'd12 || sym_count !== 3'd4 || fail_cnt !== 3'd0) begin
            bad++; $display("FAIL slide_sum got sum=%0d cnt=%0d fc=%0d exp 12/4/0", sum, sym_count, fail_cnt);
        end
    endtask

    initial begin
        test_reset();
`ifdef CYPHER_SLIDING_WINDOW_EN
        test_sliding();
`else
        test_match();
        test_fail();
        test_lockout();
        test_hold_and_check_toggle();
        test_async_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
